// File: rtl/drop_sequencer.sv
// drop_sequencer: hatch drop sequencer FSM.
// Confirms a drop request, opens the hatch, holds it open, closes it,
// then waits a cooldown. Limit-switch supervision with timeout faults.
module drop_sequencer #(
   parameter int CONFIRM_CYCLES  = 4,
   parameter int TRAVEL_CYCLES   = 16,
   parameter int HOLD_CYCLES     = 32,
   parameter int COOLDOWN_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       drop_activated,
   input  logic       drop_req,
   input  logic       abort,
   input  logic       open_sw,
   input  logic       closed_sw,
   input  logic       clear_fault,
   output logic       hatch_open_cmd,
   output logic       hatch_close_cmd,
   output logic       busy,
   output logic       done,
   output logic       fault,
   output logic [7:0] drop_count
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_CONFIRM  = 3'd1;
   localparam logic [2:0] S_OPENING  = 3'd2;
   localparam logic [2:0] S_HOLD     = 3'd3;
   localparam logic [2:0] S_CLOSING  = 3'd4;
   localparam logic [2:0] S_COOLDOWN = 3'd5;
   localparam logic [2:0] S_FAULT    = 3'd6;

   // Terminal counts, pre-sized to the counter width.
   localparam logic [15:0] CONF_LAST   = 16'(CONFIRM_CYCLES - 1);
   localparam logic [15:0] TRAVEL_LAST = 16'(TRAVEL_CYCLES - 1);
   localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYCLES - 1);
   localparam logic [15:0] COOL_LAST   = 16'(COOLDOWN_CYCLES - 1);

   logic [2:0]  state, state_nxt;
   logic [15:0] cnt;

   // Next-state selection; abort and switches take priority over timeouts.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:
            if (drop_req && drop_activated) state_nxt = S_CONFIRM;
         S_CONFIRM:
            if (!drop_req || !drop_activated || abort) state_nxt = S_IDLE;
            else if (cnt == CONF_LAST)                 state_nxt = S_OPENING;
         S_OPENING:
            if (abort)                     state_nxt = S_CLOSING;
            else if (open_sw)              state_nxt = S_HOLD;
            else if (cnt == TRAVEL_LAST)   state_nxt = S_FAULT;
         S_HOLD:
            if (abort || cnt == HOLD_LAST) state_nxt = S_CLOSING;
         S_CLOSING:
            if (closed_sw)                 state_nxt = S_COOLDOWN;
            else if (cnt == TRAVEL_LAST)   state_nxt = S_FAULT;
         S_COOLDOWN:
            if (cnt == COOL_LAST)          state_nxt = S_IDLE;
         S_FAULT:
            if (clear_fault && closed_sw)  state_nxt = S_IDLE;
         default:                          state_nxt = S_IDLE;
      endcase
   end

   // State register and per-state cycle counter (cleared on every entry).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= (state_nxt != state) ? 16'd0 : cnt + 16'd1;
      end
   end

   // Completed-drop counter; counts each closed-hatch confirmation, wraps at 256.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         drop_count <= '0;
      else if (state == S_CLOSING && state_nxt == S_COOLDOWN)
         drop_count <= drop_count + 8'd1;
   end

   // Moore output decode from registered state only.
   always_comb begin
      hatch_open_cmd  = (state == S_OPENING);
      hatch_close_cmd = (state == S_CLOSING) || (state == S_FAULT);
      busy            = (state != S_IDLE);
      done            = (state == S_COOLDOWN) && (cnt == 16'd0);
      fault           = (state == S_FAULT);
   end

endmodule
